// File: rtl/aes_word_stream_ctrl.sv
// aes_word_stream_ctrl: word-stream front/back end around an iterative AES-128 core.
// Input fill, key hold and output drain run independently of the core's run.
module aes_word_stream_ctrl #(
    parameter int NB   = 128,
    parameter int WORD = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            key_load,
    input  logic [NB-1:0]   key_in,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [WORD-1:0] s_data,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [WORD-1:0] m_data,
    output logic            busy,
    output logic            aes_start,
    output logic [NB-1:0]   aes_plain_text,
    output logic [NB-1:0]   aes_key,
    input  logic            aes_done,
    input  logic [NB-1:0]   aes_cipher_text
);
    localparam int NW = NB / WORD;
    typedef enum logic [1:0] {IDLE, START, BUSY} state_t;
    state_t state, state_nx;
    logic [NB-1:0] in_buf, key_reg, out_buf;
    logic [2:0] in_cnt, out_cnt;
    logic key_ok, capture;
    assign s_ready        = in_cnt != 3'(NW);
    assign m_valid        = out_cnt != 3'd0;
    // out_buf shifts left on each handshake, so the current word is always on top
    assign m_data         = out_buf[NB-1 -: WORD];
    assign busy           = state != IDLE;
    assign aes_plain_text = in_buf;
    assign aes_key        = key_reg;
    assign capture        = state == BUSY && aes_done && out_cnt == 3'd0;
    always_comb begin
        state_nx  = state;
        aes_start = 1'b0;
        case (state)
            IDLE:    if (in_cnt == 3'(NW) && key_ok && aes_done) state_nx = START;
            START: begin
                aes_start = 1'b1;
                state_nx  = BUSY;
            end
            BUSY:    if (capture) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            in_buf  <= '0;
            key_reg <= '0;
            out_buf <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            key_ok  <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == START) begin
                in_cnt <= '0;
            end else if (s_valid && s_ready) begin
                in_buf[(NW-1-int'(in_cnt))*WORD +: WORD] <= s_data;
                in_cnt <= in_cnt + 3'd1;
            end
            if (key_load && state != START) begin
                key_reg <= key_in;
                key_ok  <= 1'b1;
            end
            if (capture) begin
                out_buf <= aes_cipher_text;
                out_cnt <= 3'(NW);
            end else if (m_valid && m_ready) begin
                out_buf <= out_buf << WORD;
                out_cnt <= out_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_aes_word_stream_ctrl.sv
// tb_aes_word_stream_ctrl: directed bench with a behavioural iterative-core stand-in.
// Known FIPS-197 vectors are returned exactly; other inputs yield plain ^ key.
module tb_aes_word_stream_ctrl;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_X = 128'hdeadbeef0123456789abcdeffedcba98;
    localparam logic [127:0] PT_X  = 128'ha5a5a5a55a5a5a5a0f0f0f0ff0f0f0f0;

    logic clk = 0, rstn = 0, key_load = 0, s_valid = 0, m_ready = 0, ext_busy = 0;
    logic [127:0] key_in = '0;
    logic [31:0] s_data = '0;
    logic s_ready, m_valid, busy, aes_start, aes_done;
    logic [31:0] m_data;
    logic [127:0] aes_plain_text, aes_key, aes_cipher_text;
    int checks = 0, errors = 0, starts = 0;

    aes_word_stream_ctrl dut (
        .clk(clk), .rstn(rstn), .key_load(key_load), .key_in(key_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
        .aes_start(aes_start), .aes_plain_text(aes_plain_text), .aes_key(aes_key),
        .aes_done(aes_done), .aes_cipher_text(aes_cipher_text)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] ref_ct(input logic [127:0] pt, input logic [127:0] key);
        if (pt == PT_C && key == KEY_C) return CT_C;
        if (pt == PT_B && key == KEY_B) return CT_B;
        return pt ^ key;
    endfunction

    logic core_done;
    logic [127:0] core_pt, core_key, core_ct;
    int core_cnt;
    assign aes_done = core_done && !ext_busy;
    assign aes_cipher_text = core_ct;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            core_done <= 1'b1;
            core_ct   <= '0;
            core_pt   <= '0;
            core_key  <= '0;
            core_cnt  <= 0;
        end else if (aes_start && core_done) begin
            core_pt   <= aes_plain_text;
            core_key  <= aes_key;
            core_done <= 1'b0;
            core_cnt  <= 10;
        end else if (!core_done) begin
            if (core_cnt == 0) begin
                core_done <= 1'b1;
                core_ct   <= ref_ct(core_pt, core_key);
            end else begin
                core_cnt <= core_cnt - 1;
            end
        end
    end
    always @(posedge clk) if (aes_start) starts <= starts + 1;

    task automatic push(input logic [31:0] w);
        int n = 0;
        s_valid = 1'b1;
        s_data = w;
        while (!s_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: s_ready=%b word=%h", s_ready, w);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic push_block(input logic [127:0] pt);
        push(pt[127:96]);
        push(pt[95:64]);
        push(pt[63:32]);
        push(pt[31:0]);
    endtask

    task automatic load_key(input logic [127:0] k);
        key_load = 1'b1;
        key_in = k;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    task automatic drain(input bit toggle, output logic [127:0] got, output int hs, output bit stable);
        logic [31:0] held = '0;
        bit stalled = 0;
        int n = 0;
        got = '0;
        hs = 0;
        stable = 1;
        while (hs < 4 && n < 200) begin
            m_ready = toggle ? n[0] : 1'b1;
            if (stalled && m_data !== held) stable = 0;
            stalled = 0;
            if (m_valid && m_ready) begin
                got = {got[95:0], m_data};
                hs++;
            end else if (m_valid) begin
                stalled = 1;
                held = m_data;
            end
            @(negedge clk);
            n++;
        end
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", aes_start); end
        checks++; if (aes_key !== 128'h0) begin errors++; $display("FAIL reset_key: got %h want 0", aes_key); end
        checks++; if (aes_plain_text !== 128'h0) begin errors++; $display("FAIL reset_pt: got %h want 0", aes_plain_text); end
    endtask

    task automatic test_no_key();
        logic [127:0] got;
        int hs, s0;
        bit st;
        s0 = starts;
        push_block(PT_C);
        repeat (5) @(negedge clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL nokey_s_ready: got %b want 0", s_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nokey_busy: got %b want 0", busy); end
        checks++; if (starts !== s0) begin errors++; $display("FAIL nokey_starts: got %0d want %0d", starts, s0); end
        load_key(KEY_C);
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL nokey_start_early: got %b want 0", aes_start); end
        @(negedge clk);
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL nokey_start: got %b want 1", aes_start); end
        checks++; if (aes_key !== KEY_C) begin errors++; $display("FAIL nokey_key: got %h want %h", aes_key, KEY_C); end
        drain(0, got, hs, st);
        checks++; if (got !== CT_C) begin errors++; $display("FAIL nokey_ct: got %h want %h", got, CT_C); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL nokey_drained: m_valid=%b want 0", m_valid); end
    endtask

    task automatic test_fips();
        logic [127:0] got;
        int hs, s0;
        bit st;
        load_key(KEY_C);
        m_ready = 1'b1;
        s0 = starts;
        push_block(PT_C);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL fips_start_t1: got %b want 1", aes_start); end
                checks++; if (aes_plain_text !== PT_C) begin errors++; $display("FAIL fips_pt: got %h want %h", aes_plain_text, PT_C); end
                checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fips_s_ready_start: got %b want 0", s_ready); end
            end
            if (k == 2) begin
                checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL fips_start_t2: got %b want 0", aes_start); end
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL fips_s_ready_back: got %b want 1", s_ready); end
            end
            if (k == 13) begin
                checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fips_m_valid_t13: got %b want 0", m_valid); end
            end
        end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL fips_m_valid_t14: got %b want 1", m_valid); end
        checks++; if (starts !== s0 + 1) begin errors++; $display("FAIL fips_starts: got %0d want %0d", starts, s0 + 1); end
        drain(0, got, hs, st);
        checks++; if (got !== CT_C) begin errors++; $display("FAIL fips_ct: got %h want %h", got, CT_C); end
        checks++; if (hs !== 4) begin errors++; $display("FAIL fips_hs: got %0d want 4", hs); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL fips_drained: m_valid=%b want 0", m_valid); end
    endtask

    task automatic test_core_busy();
        logic [127:0] got;
        int hs, s0;
        bit st;
        s0 = starts;
        ext_busy = 1'b1;
        push_block(PT_X);
        repeat (4) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL corebusy_busy: got %b want 0", busy); end
        checks++; if (starts !== s0) begin errors++; $display("FAIL corebusy_starts: got %0d want %0d", starts, s0); end
        ext_busy = 1'b0;
        @(negedge clk);
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL corebusy_start: got %b want 1", aes_start); end
        drain(0, got, hs, st);
        checks++; if (got !== (PT_X ^ KEY_C)) begin errors++; $display("FAIL corebusy_ct: got %h want %h", got, PT_X ^ KEY_C); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] got, ct2;
        logic [31:0] w0;
        int hs, s0, n;
        bit st;
        ct2 = ref_ct(PT_B, KEY_C);
        w0 = ct2[127:96];
        m_ready = 1'b0;
        s0 = starts;
        push_block(PT_C);
        push_block(PT_B);
        n = 0;
        while (!m_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_result: m_valid=%b want 1", m_valid); end
        checks++; if (starts !== s0 + 1) begin errors++; $display("FAIL b2b_one_start: got %0d want %0d", starts, s0 + 1); end
        @(negedge clk);
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL b2b_second_start: got %b want 1", aes_start); end
        repeat (20) @(negedge clk);
        checks++; if (m_data !== CT_C[127:96]) begin errors++; $display("FAIL b2b_held: got %h want %h", m_data, CT_C[127:96]); end
        drain(0, got, hs, st);
        checks++; if (got !== CT_C) begin errors++; $display("FAIL b2b_first_ct: got %h want %h", got, CT_C); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL b2b_bubble: m_valid=%b want 0", m_valid); end
        @(negedge clk);
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", m_valid); end
        checks++; if (m_data !== w0) begin errors++; $display("FAIL b2b_second_w0: got %h want %h", m_data, w0); end
        checks++; if (starts !== s0 + 2) begin errors++; $display("FAIL b2b_starts: got %0d want %0d", starts, s0 + 2); end
    endtask

    task automatic test_backpressure();
        logic [127:0] got;
        int hs;
        bit st;
        drain(1, got, hs, st);
        checks++; if (got !== ref_ct(PT_B, KEY_C)) begin errors++; $display("FAIL bp_ct: got %h want %h", got, ref_ct(PT_B, KEY_C)); end
        checks++; if (hs !== 4) begin errors++; $display("FAIL bp_hs: got %0d want 4", hs); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", st); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: m_valid=%b want 0", m_valid); end
    endtask

    task automatic test_key_timing();
        logic [127:0] got;
        int hs;
        bit st;
        m_ready = 1'b1;
        push_block(PT_C);
        @(negedge clk);
        checks++; if (aes_start !== 1'b1) begin errors++; $display("FAIL keyt_start: got %b want 1", aes_start); end
        load_key(KEY_X);
        checks++; if (aes_key !== KEY_C) begin errors++; $display("FAIL keyt_start_ignored: got %h want %h", aes_key, KEY_C); end
        load_key(KEY_B);
        checks++; if (aes_key !== KEY_B) begin errors++; $display("FAIL keyt_busy_load: got %h want %h", aes_key, KEY_B); end
        drain(0, got, hs, st);
        checks++; if (got !== CT_C) begin errors++; $display("FAIL keyt_old_key_ct: got %h want %h", got, CT_C); end
        push_block(PT_B);
        drain(0, got, hs, st);
        checks++; if (got !== CT_B) begin errors++; $display("FAIL keyt_new_key_ct: got %h want %h", got, CT_B); end
    endtask

    task automatic test_reset_mid();
        logic [127:0] got;
        int hs;
        bit st;
        push_block(PT_B);
        repeat (3) @(negedge clk);
        push(PT_C[127:96]);
        push(PT_C[95:64]);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
        #1 rstn = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmid_s_ready: got %b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rmid_m_data: got %h want 0", m_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (aes_start !== 1'b0) begin errors++; $display("FAIL rmid_start: got %b want 0", aes_start); end
        checks++; if (aes_key !== 128'h0) begin errors++; $display("FAIL rmid_key: got %h want 0", aes_key); end
        checks++; if (aes_plain_text !== 128'h0) begin errors++; $display("FAIL rmid_pt: got %h want 0", aes_plain_text); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        load_key(KEY_B);
        push_block(PT_B);
        drain(0, got, hs, st);
        checks++; if (got !== CT_B) begin errors++; $display("FAIL rmid_ct: got %h want %h", got, CT_B); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_no_key();
        test_fips();
        test_core_busy();
        test_back_to_back();
        test_backpressure();
        test_key_timing();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
